// File: rtl/param_convert_pipe_if.sv
// Purpose : handshake/bus bundle for param_convert_pipe (input stream, output stream, ovf counter).
// Latency : none, this is wiring only.
// Backpr. : carries valid/ready in both directions. in_ready is driven by the converter.
//
// Ports (signals):
//   in_valid/in_ready/in_data         upstream transfer, channel k at [k*IN_W +: IN_W]
//   out_valid/out_ready/out_data      downstream transfer, channel k at [k*OUT_W +: OUT_W]
//   out_sign/out_ovf                  per-channel sign-check bit and not-representable flag
//   ovf_count/ovf_clear               saturating overflow event counter and its synchronous clear
// Modports: master = stimulus/checker side, slave = converter side.
interface param_convert_pipe_if #(
    parameter int NCH   = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 6,
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NCH*IN_W-1:0]    in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [NCH*OUT_W-1:0]   out_data;
    logic [NCH-1:0]         out_sign;
    logic [NCH-1:0]         out_ovf;
    logic [CNT_W-1:0]       ovf_count;
    logic                   ovf_clear;

    modport master (
        output in_valid, in_data, out_ready, ovf_clear,
        input  in_ready, out_valid, out_data, out_sign, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clear,
        output in_ready, out_valid, out_data, out_sign, out_ovf, ovf_count
    );
endinterface

// File: rtl/param_convert_pipe.sv
// Purpose : converts NCH packed elements from IN_W/IN_SIGNED to OUT_W/OUT_SIGNED (wrap or clamp).
// Latency : 2 cycles from input handshake to out_valid, 1 transfer per cycle.
// Backpr. : in_ready = !s1_valid || s1_advance. Stage 2 holds its outputs while out_ready=0.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset. It empties both stages and clears ovf_count.
//   bus    param_convert_pipe_if.slave. It carries in_*/out_* handshakes, out_sign, out_ovf,
//          ovf_count and ovf_clear.
module param_convert_pipe #(
    parameter int NCH        = 4,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 6,
    parameter bit IN_SIGNED  = 1'b1,
    parameter bit OUT_SIGNED = 1'b0,
    parameter bit SATURATE   = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    param_convert_pipe_if.slave  bus
);

    if (NCH < 1) begin : g_bad_nch
        $fatal(1, "param_convert_pipe: NCH must be >= 1");
    end
    if (IN_W < 1) begin : g_bad_in_w
        $fatal(1, "param_convert_pipe: IN_W must be >= 1");
    end
    if (OUT_W < 1) begin : g_bad_out_w
        $fatal(1, "param_convert_pipe: OUT_W must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $fatal(1, "param_convert_pipe: CNT_W must be >= 1");
    end

    // Two guard bits above the wider of the two types. Any source value and both
    // output range limits are then exact in E-bit two's complement, so a single
    // signed compare decides the range check.
    localparam int E     = ((IN_W > OUT_W) ? IN_W : OUT_W) + 2;
    localparam int PC_W  = $clog2(NCH + 1);
    localparam int SUM_W = CNT_W + PC_W;

    localparam logic [E-1:0] ONE_E = E'(1);
    localparam logic [E-1:0] MAX_V = OUT_SIGNED ? ((ONE_E << (OUT_W - 1)) - ONE_E)
                                                : ((ONE_E << OUT_W) - ONE_E);
    localparam logic [E-1:0] MIN_V = OUT_SIGNED ? ~((ONE_E << (OUT_W - 1)) - ONE_E)
                                                : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ---------------------------------------------------------------- state
    logic                       s1_valid_q, s1_valid_d;
    logic [NCH-1:0][E-1:0]      s1_ext_q, s1_ext_d;
    logic                       s2_valid_q, s2_valid_d;
    logic [NCH*OUT_W-1:0]       s2_data_q, s2_data_d;
    logic [NCH-1:0]             s2_sign_q, s2_sign_d;
    logic [NCH-1:0]             s2_ovf_q, s2_ovf_d;
    logic [CNT_W-1:0]           ovf_cnt_q, ovf_cnt_d;

    // ---------------------------------------------------------------- combinational
    logic                       s1_adv;
    logic                       in_rdy;
    logic                       out_hs;
    logic [NCH-1:0][E-1:0]      ext_in;
    logic [NCH*OUT_W-1:0]       conv_dat;
    logic [NCH-1:0]             conv_sign;
    logic [NCH-1:0]             conv_ovf;
    logic [PC_W-1:0]            ovf_pop;
    logic [SUM_W-1:0]           cnt_sum;

    function automatic logic [PC_W-1:0] popcnt(input logic [NCH-1:0] f);
        logic [PC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NCH; i++) begin
            acc = acc + PC_W'(f[i]);
        end
        return acc;
    endfunction

    // in_ready depends on out_ready only, never on in_valid.
    assign s1_adv = !s2_valid_q || bus.out_ready;
    assign in_rdy = !s1_valid_q || s1_adv;
    assign out_hs = s2_valid_q && bus.out_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [IN_W-1:0]  raw;
        logic             fill;
        logic [E-1:0]     v;
        logic             above;
        logic             below;
        logic [OUT_W-1:0] res;

        // Stage-1 input side: widen to E bits under the source signedness.
        assign raw       = bus.in_data[k*IN_W +: IN_W];
        assign fill      = IN_SIGNED & raw[IN_W-1];
        assign ext_in[k] = {{(E - IN_W){fill}}, raw};

        // Stage-2 input side: range check against the output type, then wrap or clamp.
        assign v     = s1_ext_q[k];
        assign above = $signed(v) > $signed(MAX_V);
        assign below = $signed(v) < $signed(MIN_V);
        assign res   = (SATURATE && above) ? MAX_V[OUT_W-1:0] :
                       (SATURATE && below) ? MIN_V[OUT_W-1:0] :
                                             v[OUT_W-1:0];

        assign conv_dat[k*OUT_W +: OUT_W] = res;
        assign conv_ovf[k]                = above | below;
        // Bit OUT_W of the result re-extended to OUT_W+1 bits. For an unsigned output
        // that bit is always a zero-extension bit.
        assign conv_sign[k]               = OUT_SIGNED ? res[OUT_W-1] : 1'b0;
    end

    assign ovf_pop = popcnt(s2_ovf_q);
    assign cnt_sum = SUM_W'(ovf_cnt_q) + SUM_W'(ovf_pop);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ext_d   = s1_ext_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sign_d  = s2_sign_q;
        s2_ovf_d   = s2_ovf_q;
        ovf_cnt_d  = ovf_cnt_q;

        if (in_rdy) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_ext_d = ext_in;
            end
        end

        // Stage 2 payload only changes on a real load. A bubble just drops out_valid.
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = conv_dat;
                s2_sign_d = conv_sign;
                s2_ovf_d  = conv_ovf;
            end
        end

        // Clear has priority over a same-cycle increment.
        if (bus.ovf_clear) begin
            ovf_cnt_d = '0;
        end else if (out_hs) begin
            ovf_cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ext_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sign_q  <= '0;
            s2_ovf_q   <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ext_q   <= s1_ext_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sign_q  <= s2_sign_d;
            s2_ovf_q   <= s2_ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_ovf   = s2_ovf_q;
    assign bus.ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_param_convert_pipe.sv
// Purpose : directed bench for param_convert_pipe across several width/sign/saturate configs.
// Latency : expects 2-cycle input-to-output latency and 1 transfer/cycle.
// Backpr. : drives out_ready low for a window and checks stall, hold and ordering.
module tb_param_convert_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clear;
    logic [31:0] d8;
    logic [19:0] d5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // if0 is the default config (8s->6u wrap). if1 is 8s->6u sat, if2 is 8s->6s wrap,
    // if3 is 8s->6s sat, if4 is 5u->6s wrap, if5 is 5s->6u wrap, if6 is 5s->6u sat,
    // and if7 is the default config with a 4-bit counter.
    param_convert_pipe_if #(.NCH(4), .IN_W(8), .OUT_W(6), .CNT_W(16)) if0 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(8), .OUT_W(6), .CNT_W(16)) if1 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(8), .OUT_W(6), .CNT_W(16)) if2 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(8), .OUT_W(6), .CNT_W(16)) if3 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(5), .OUT_W(6), .CNT_W(16)) if4 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(5), .OUT_W(6), .CNT_W(16)) if5 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(5), .OUT_W(6), .CNT_W(16)) if6 ();
    param_convert_pipe_if #(.NCH(4), .IN_W(8), .OUT_W(6), .CNT_W(4))  if7 ();

    assign if0.in_valid = in_valid; assign if0.in_data = d8; assign if0.out_ready = out_ready; assign if0.ovf_clear = ovf_clear;
    assign if1.in_valid = in_valid; assign if1.in_data = d8; assign if1.out_ready = out_ready; assign if1.ovf_clear = ovf_clear;
    assign if2.in_valid = in_valid; assign if2.in_data = d8; assign if2.out_ready = out_ready; assign if2.ovf_clear = ovf_clear;
    assign if3.in_valid = in_valid; assign if3.in_data = d8; assign if3.out_ready = out_ready; assign if3.ovf_clear = ovf_clear;
    assign if4.in_valid = in_valid; assign if4.in_data = d5; assign if4.out_ready = out_ready; assign if4.ovf_clear = ovf_clear;
    assign if5.in_valid = in_valid; assign if5.in_data = d5; assign if5.out_ready = out_ready; assign if5.ovf_clear = ovf_clear;
    assign if6.in_valid = in_valid; assign if6.in_data = d5; assign if6.out_ready = out_ready; assign if6.ovf_clear = ovf_clear;
    assign if7.in_valid = in_valid; assign if7.in_data = d8; assign if7.out_ready = out_ready; assign if7.ovf_clear = ovf_clear;

    param_convert_pipe #(.NCH(4), .IN_W(8), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(0), .SATURATE(0), .CNT_W(16))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    param_convert_pipe #(.NCH(4), .IN_W(8), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(0), .SATURATE(1), .CNT_W(16))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    param_convert_pipe #(.NCH(4), .IN_W(8), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(1), .SATURATE(0), .CNT_W(16))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    param_convert_pipe #(.NCH(4), .IN_W(8), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(1), .SATURATE(1), .CNT_W(16))
        u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    param_convert_pipe #(.NCH(4), .IN_W(5), .OUT_W(6), .IN_SIGNED(0), .OUT_SIGNED(1), .SATURATE(0), .CNT_W(16))
        u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    param_convert_pipe #(.NCH(4), .IN_W(5), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(0), .SATURATE(0), .CNT_W(16))
        u5 (.clk(clk), .rst_n(rst_n), .bus(if5));
    param_convert_pipe #(.NCH(4), .IN_W(5), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(0), .SATURATE(1), .CNT_W(16))
        u6 (.clk(clk), .rst_n(rst_n), .bus(if6));
    param_convert_pipe #(.NCH(4), .IN_W(8), .OUT_W(6), .IN_SIGNED(1), .OUT_SIGNED(0), .SATURATE(0), .CNT_W(4))
        u7 (.clk(clk), .rst_n(rst_n), .bus(if7));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          got;
        logic        stalled_prev;
        logic [23:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0; d8 = '0; d5 = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_out_data",  if0.out_data, 0);
        chk("rst_out_sign",  if0.out_sign, 0);
        chk("rst_out_ovf",   if0.out_ovf, 0);
        chk("rst_ovf_count", if0.ovf_count, 0);
        rst_n = 1'b1;
        step();

        // Lane values: 8-bit lanes are -88, 5, 63, 64. 5-bit lanes are 11010, 11111, 0, 10000.
        in_valid = 1'b1;
        d8 = {8'h40, 8'h3F, 8'h05, 8'hA8};
        d5 = {5'b10000, 5'b00000, 5'b11111, 5'b11010};
        #1;
        chk("in_ready_idle", if0.in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lat1_no_valid", if0.out_valid, 0);
        step();
        chk("lat2_valid",   if0.out_valid, 1);
        chk("s8u_wrap_dat", if0.out_data, {6'd0, 6'd63, 6'd5, 6'd40});
        chk("s8u_wrap_ovf", if0.out_ovf, 4'b1001);
        chk("s8u_wrap_sgn", if0.out_sign, 4'b0000);
        chk("s8u_sat_dat",  if1.out_data, {6'd63, 6'd63, 6'd5, 6'd0});
        chk("s8u_sat_ovf",  if1.out_ovf, 4'b1001);
        chk("s8s_wrap_dat", if2.out_data, {6'd0, 6'd63, 6'd5, 6'd40});
        chk("s8s_wrap_ovf", if2.out_ovf, 4'b1101);
        chk("s8s_wrap_sgn", if2.out_sign, 4'b0101);
        chk("s8s_sat_dat",  if3.out_data, {6'd31, 6'd31, 6'd5, 6'd32});
        chk("s8s_sat_ovf",  if3.out_ovf, 4'b1101);
        chk("s8s_sat_sgn",  if3.out_sign, 4'b0001);
        chk("u5s_wrap_dat", if4.out_data, {6'd16, 6'd0, 6'd31, 6'd26});
        chk("u5s_wrap_ovf", if4.out_ovf, 4'b0000);
        chk("u5s_wrap_sgn", if4.out_sign, 4'b0000);
        chk("s5u_wrap_dat", if5.out_data, {6'd48, 6'd0, 6'd63, 6'd58});
        chk("s5u_wrap_ovf", if5.out_ovf, 4'b1011);
        chk("s5u_sat_dat",  if6.out_data, 24'd0);
        chk("s5u_sat_ovf",  if6.out_ovf, 4'b1011);
        chk("cnt_before_hs", if0.ovf_count, 0);
        step();
        chk("cnt_after_hs", if0.ovf_count, 2);
        chk("cnt4_after_hs", if7.ovf_count, 2);
        chk("bubble_valid", if0.out_valid, 0);

        // Backpressure: 5 transfers, out_ready low for loop cycles 3..6.
        sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 5);
            d8        = 32'(sent + 1);
            #1;
            if (c == 2) chk("bp_rdy_flow", if0.in_ready, 1);
            if (c == 3) chk("bp_rdy_full", if0.in_ready, 0);
            if (c == 7) chk("bp_rdy_release", if0.in_ready, 1);
            if (stalled_prev) chk("bp_stable", if0.out_data, held);
            stalled_prev = if0.out_valid && !out_ready;
            held = if0.out_data;
            if (in_valid && if0.in_ready) sent++;
            if (if0.out_valid && out_ready) begin
                chk("bp_order", if0.out_data, 24'(got + 1));
                got++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_sent", sent, 5);
        chk("bp_got", got, 5);
        step();
        step();
        chk("bp_no_dup", if0.out_valid, 0);
        chk("bp_cnt_kept", if0.ovf_count, 2);

        // Counter saturation: 4 transfers with 4 ovf lanes each take 2 to 18, so CNT_W=4 clamps at 15.
        in_valid = 1'b1;
        d8 = 32'hA8A8A8A8;
        repeat (4) step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("cnt4_saturated", if7.ovf_count, 15);
        chk("cnt16_sum", if0.ovf_count, 18);

        // A clear in the same cycle as an ovf handshake leaves the counter at 0.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_xfer_valid", if7.out_valid, 1);
        chk("clr_xfer_ovf", if7.out_ovf, 4'b1111);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        chk("clr_wins_cnt4", if7.ovf_count, 0);
        chk("clr_wins_cnt16", if0.ovf_count, 0);

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1;
        repeat (3) step();
        chk("mid_valid", if0.out_valid, 1);
        chk("mid_cnt", if0.ovf_count, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", if0.out_valid, 0);
        chk("arst_cnt", if0.ovf_count, 0);
        chk("arst_data", if0.out_data, 0);
        #1;
        in_valid = 1'b1;
        d8 = 32'd5;
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_lat1", if0.out_valid, 0);
        step();
        chk("post_rst_lat2", if0.out_valid, 1);
        chk("post_rst_data", if0.out_data, 24'd5);
        step();
        chk("post_rst_drain", if0.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_convert_pipe.md
Name: param_convert_pipe

Overview:
- Multi-channel, pipelined converter that applies parameter-assignment width/sign semantics to a stream of values.
- Each input element is interpreted at IN_W bits with IN_SIGNED signedness, then converted to OUT_W bits with OUT_SIGNED signedness, either by wrapping or by saturating.
- Per element, the block also reports a sign-check bit and an overflow flag.
- Sits between a stimulus source and a checker in cosim and elaboration-model benches; one transfer per cycle with valid/ready backpressure.

Parameters:
NCH, 4, number of channels packed per transfer (>=1)
IN_W, 8, input element width (>=1)
OUT_W, 6, output element width (>=1)
IN_SIGNED, 1, 1 = input elements are two's complement, 0 = unsigned
OUT_SIGNED, 0, 1 = output type is signed, 0 = unsigned
SATURATE, 0, 0 = wrap (truncate/extend), 1 = clamp to output range
CNT_W, 16, width of the overflow event counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  input transfer valid
in_ready  output  1  block can accept the input transfer
in_data  input  NCH*IN_W  channel k occupies bits [k*IN_W +: IN_W]
out_valid  output  1  output transfer valid
out_ready  input  1  downstream accepts the output transfer
out_data  output  NCH*OUT_W  converted elements, same channel packing
out_sign  output  NCH  per-channel sign-check bit
out_ovf  output  NCH  per-channel: source value not representable in the output type
ovf_count  output  CNT_W  saturating count of accepted output elements with ovf=1
ovf_clear  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sign=0, out_ovf=0, ovf_count=0; both pipeline stages empty.
- Pipeline has 2 register stages. Latency is 2 cycles from input handshake to out_valid with no stall. Full throughput of 1 transfer/cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - in_ready = !s1_valid || s1_advance; s1_advance = !s2_valid || out_ready.
  - Stage 2 loads when it is empty or out_ready=1. It holds when out_valid=1 and out_ready=0.
  - out_data, out_sign and out_ovf stay stable while out_valid=1 and out_ready=0.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Stage 1:
  - Register each element extended to E = max(IN_W, OUT_W)+2 bits: sign-extend if IN_SIGNED, else zero-extend.
  - Register the valid bit.
- Stage 2 conversion, per element, with v = the extended value:
  - Wrap: out = v[OUT_W-1:0].
  - Saturate, OUT_SIGNED=1: clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Saturate, OUT_SIGNED=0: clamp v to [0, 2^OUT_W-1].
  - ovf = v is outside the output range (same range as saturation), independent of SATURATE.
  - sign = bit OUT_W of out extended to OUT_W+1 bits under OUT_SIGNED. Equals out[OUT_W-1] if OUT_SIGNED, else always 0; source signedness is irrelevant.
- ovf_count:
  - On each output handshake, add popcount(out_ovf); saturate at 2^CNT_W-1, no wrap.
  - ovf_clear=1 forces 0 that cycle. Clear wins over a simultaneous increment.
- Identity config (IN_W=OUT_W, IN_SIGNED=OUT_SIGNED): out = in, ovf = 0.
- Reset mid-stream: in-flight data is discarded; the first post-reset output appears 2 cycles after the first accepted input.
- Elaboration fails if NCH, IN_W, OUT_W or CNT_W is less than 1.

Test Plan:
- Defaults (IN_W=8, signed, OUT_W=6, unsigned, wrap), ch0 = 8'b10101000 (-88), out_ready=1:
  - after 2 cycles, out=6'b101000 (40), sign=0, ovf=1; ovf_count becomes 1.
- Same input, SATURATE=1:
  - out=6'b000000, sign=0, ovf=1.
- OUT_SIGNED=1, same input:
  - wrap: out=6'b101000 (-24), sign=1, ovf=1.
  - saturate: out=6'b100000 (-32), sign=1, ovf=1.
- IN_W=5, OUT_W=6:
  - input 5'b11010 unsigned (26) into signed 6: out=6'b011010, sign=0, ovf=0.
  - input 5'b11010 signed (-6) into unsigned 6: wrap out=6'b111010 (58), ovf=1; saturate out=0.
- Backpressure:
  - Stream 5 transfers with out_ready low for cycles 3-6: in_ready drops once both stages are full; out_data stays stable while stalled.
  - All 5 outputs arrive in order, none lost or duplicated.
- Counter and reset:
  - Preload ovf_count to max (CNT_W=4, 15) and assert ovf_clear together with an ovf transfer: count goes to 0.
  - Assert rst_n=0 mid-stream, asynchronously: out_valid=0 immediately and ovf_count=0.
